pio_led_fader: RTL
==================

# pio_led_fader

Downstream consumer of the 7-bit Nios II PIO output port. Each PIO bit drives one channel. Setting a bit ramps that channel's LED brightness up linearly to full; clearing it ramps the brightness down to off. Brightness is rendered as PWM on the board LED pins, and a `busy` flag tells software polling through another PIO when all ramps have settled.

## Interface
- `WIDTH`, default 7: number of channels; matches the PIO output width.
- `PWM_BITS`, default 8: width of the brightness level and PWM counter. Legal range 2..16.
- `STEP_DIV`, default 1000: clocks per brightness step. Must be ≥1.

Ports (clock and reset first):
- `clk`, input, 1: system clock, shared with the PIO.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `pio_in`, input, `WIDTH`: channel targets, connected to the PIO `out_port`.
- `led`, output, `WIDTH`: PWM outputs, active-high, registered.
- `busy`, output, 1: high while any channel is not at its target endpoint.

## Operation
**Input stage**
- `pio_in` is registered into `pio_q`. `pio_q[i]=1` sets the target of channel i to MAX = 2^PWM_BITS−1; `pio_q[i]=0` sets it to 0.

**Prescaler**
- Free-running counter from 0 to STEP_DIV−1, wrapping to 0.
- `tick` is high in the cycle where the counter equals STEP_DIV−1.
- With STEP_DIV=1, `tick` is high every cycle.

**Level update**
- Each channel has a `PWM_BITS`-wide `level[i]`.
- On a `tick` edge:
  - target MAX and `level[i]` < MAX: `level[i]` increments by 1.
  - target 0 and `level[i]` > 0: `level[i]` decrements by 1.
  - otherwise: `level[i]` holds.
- Levels saturate and never wrap.

**Direction reversal**
- A target change mid-ramp reverses direction from the current level on the next tick. There is no jump and no restart.

**PWM counter**
- `pwm_cnt`, `PWM_BITS` wide, increments every cycle and wraps from MAX to 0.

**LED output**
- `led[i]` is registered: it is 1 when `level[i]`==MAX or `level[i]` > `pwm_cnt`, else 0.
- Level 0 gives constant off. Level MAX gives constant on. Level L with 0<L<MAX gives exactly L high cycles per 2^PWM_BITS-cycle period.

**Busy**
- `busy` = OR over i of (`level[i]` ≠ target endpoint of `pio_q[i]`).
- It is decoded from registers only; there is no combinational path from `pio_in`.

**Ramp duration**
- A full ramp takes MAX ticks, i.e. MAX×STEP_DIV cycles ±STEP_DIV for tick phase.

**Reset**
- Reset forces all of the following to 0 immediately, regardless of `clk`: `pio_q`, sync flops, `level[*]`, prescaler, `pwm_cnt`, `led`, `busy`.

## Timing
- `pio_in` → `pio_q`: 1 clock edge.
- `busy` follows `pio_q` in the same cycle, so it responds 1 cycle after a `pio_in` change.
- The first level change happens on the first `tick` edge at or after `pio_q` updates.
  - The ticks are not re-phased on a target change.
  - The prescaler is never reset by `pio_in`.
- `led` lags (`level`, `pwm_cnt`) by 1 cycle.
- First `tick` after reset release: the STEP_DIV-th rising edge.
- A `pio_in` toggle shorter than one cycle that is not sampled is ignored.
- A target flip-back before any tick leaves `level` unchanged. `busy` still pulses while `pio_q` differs from the endpoint.

## Configuration
Macro: `LED_FADE_SYNC_EN`.
- **Defined:** `pio_in` passes through a 2-flop synchronizer before the input stage, for use when `pio_in` comes from an asynchronous source. `pio_in`→`pio_q` latency becomes 2 cycles, and `busy` responds 2 cycles after the `pio_in` change.
- **Undefined:** single register stage with 1-cycle latency, as described above.

## Test plan
1. **Reset.** Hold `reset_n`=0 with `pio_in`=7'h7F for 20 cycles → `led`=0, `busy`=0 throughout. Release → all levels start from 0.
2. **Full ramp up** (PWM_BITS=4, STEP_DIV=4). Set `pio_in`=7'h01 → `busy`=1 from the next cycle.
   - `level[0]` reaches 15 after 15 ticks (≈60 cycles), then `busy`=0 and `led[0]` is constantly 1.
   - `led[6:1]` stays 0.
3. **PWM duty** (PWM_BITS=4, STEP_DIV=256). During each 256-cycle plateau at level L (1..14), every aligned 16-cycle window shows exactly L high cycles on `led[0]`.
4. **Reversal** (PWM_BITS=4, STEP_DIV=4). Ramp to `level[0]`=5, then clear bit 0 → the level goes 5,4,3,2,1,0 on consecutive ticks, with no step above 5. `busy` falls when the level reaches 0.
5. **Asynchronous reset mid-ramp.** Pull `reset_n` low between clock edges at level 9 → `led`=0, `busy`=0 and levels=0 before the next rising edge.
6. **Sync macro.** Toggle `pio_in[3]` at a known edge → `busy` rises 1 cycle later without `LED_FADE_SYNC_EN`, and 2 cycles later with it.

Source files
------------

// File: rtl/pio_led_fader.sv
// Per-channel linear LED fader driven by a Nios II PIO word, rendered as PWM.
// Define LED_FADE_SYNC_EN to add a 2-flop synchronizer on pio_in for asynchronous sources.
module pio_led_fader #(
    parameter int WIDTH    = 7,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] led,
    output logic             busy
);

    localparam int                  PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] LVL_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]    pio_q_r;
    logic [PRE_W-1:0]    pre_cnt_r;
    logic                tick_s;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PWM_BITS-1:0] level_r     [WIDTH];
    logic [PWM_BITS-1:0] level_nxt_s [WIDTH];
    logic [WIDTH-1:0]    led_r;
    logic                busy_s;

    function automatic logic [PWM_BITS-1:0] endpoint(input logic tgt);
        return tgt ? LVL_MAX : LVL_ZERO;
    endfunction

`ifdef LED_FADE_SYNC_EN
    logic [WIDTH-1:0] sync_r;

    // Two-flop synchronizer; the second stage is the target register itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r  <= {WIDTH{1'b0}};
            pio_q_r <= {WIDTH{1'b0}};
        end else begin
            sync_r  <= pio_in;
            pio_q_r <= sync_r;
        end
    end
`else
    // Single target register stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_q_r <= {WIDTH{1'b0}};
        end else begin
            pio_q_r <= pio_in;
        end
    end
`endif

    // Step tick: last count of the free-running prescaler, never re-phased by pio_in.
    always_comb begin
        tick_s = (pre_cnt_r == PRE_LAST);
    end

    // Prescaler counts 0..STEP_DIV-1 and wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else if (tick_s) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
        end
    end

    // PWM period counter wraps naturally from MAX to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_r <= LVL_ZERO;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + LVL_ONE;
        end
    end

    // Saturating one-step move toward the current endpoint on each tick.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            level_nxt_s[i] = level_r[i];
            if (!tick_s) begin
                level_nxt_s[i] = level_r[i];
            end else if (pio_q_r[i] && (level_r[i] != LVL_MAX)) begin
                level_nxt_s[i] = level_r[i] + LVL_ONE;
            end else if (!pio_q_r[i] && (level_r[i] != LVL_ZERO)) begin
                level_nxt_s[i] = level_r[i] - LVL_ONE;
            end else begin
                level_nxt_s[i] = level_r[i];
            end
        end
    end

    // Brightness level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                level_r[i] <= LVL_ZERO;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                level_r[i] <= level_nxt_s[i];
            end
        end
    end

    // MAX is forced fully on so the top level has no one-cycle dropout per period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_r <= {WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                led_r[i] <= (level_r[i] == LVL_MAX) || (level_r[i] > pwm_cnt_r);
            end
        end
    end

    // Busy decodes registered state only, so it tracks pio_q in the same cycle.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            busy_s = busy_s | (level_r[i] != endpoint(pio_q_r[i]));
        end
    end

    assign led  = led_r;
    assign busy = busy_s;

endmodule
